prog_mem: RTL and testbench
===========================

PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 Parameter ADDR_W, default 4, address width; depth DEPTH = 2**ADDR_W words.
REQ-002 Parameter INSTR_W, default 16, instruction width; SHALL be a multiple of 8; NB = INSTR_W/8 bytes per word.
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 fetch_en  input  1  fetch request for fetch_addr.
REQ-006 fetch_addr  input  ADDR_W  word address to fetch.
REQ-007 instruction  output  INSTR_W  registered fetched word.
REQ-008 instr_valid  output  1  instruction holds the word for the previous cycle's accepted fetch.
REQ-009 load_start  input  1  one-cycle request to begin reloading memory from address 0.
REQ-010 ld_valid  input  1  ld_data byte offered.
REQ-011 ld_data  input  8  load byte.
REQ-012 ld_last  input  1  qualifies the final byte of the load stream.
REQ-013 ld_ready  output  1  block accepts the byte this cycle.
REQ-014 load_busy  output  1  high while a load is in progress.
REQ-015 load_done  output  1  one-cycle pulse at load completion.
REQ-016 load_count  output  ADDR_W+1  words written by the most recent load.

Function
REQ-017 FSM states IDLE, RECV, WRITE, FINISH; reset state IDLE.
REQ-018 IDLE: load_start=1 -> RECV, clear word pointer, byte index and load_count; load_start ignored in all other states.
REQ-019 RECV: ld_ready=1; a byte transfers when ld_valid&ld_ready; the first byte of a word fills the MS byte, following bytes fill progressively lower bytes.
REQ-020 RECV -> WRITE after the NB-th byte of a word, or on any byte with ld_last=1.
REQ-021 ld_last on a byte other than the NB-th zero-fills the remaining low bytes of that word.
REQ-022 WRITE: ld_ready=0; write the assembled word to mem[pointer], increment pointer and load_count, clear byte index.
REQ-023 WRITE -> FINISH if the word ended with ld_last or pointer was DEPTH-1; otherwise -> RECV.
REQ-024 Bytes after the DEPTH-th word are not accepted; the pointer never wraps.
REQ-025 FINISH: load_done=1 for exactly one cycle, then -> IDLE.
REQ-026 load_busy=1 in RECV, WRITE, FINISH; 0 in IDLE.
REQ-027 Fetch: in IDLE with fetch_en=1, instruction <= mem[fetch_addr] and instr_valid <= 1 next cycle (latency 1); otherwise instr_valid <= 0 and instruction holds.
REQ-028 fetch_en in the same cycle as load_start: load wins, fetch dropped, instr_valid=0 next cycle.
REQ-029 Words not rewritten by a load keep their prior contents.
REQ-030 Power-up memory contents are all-zero (NOP encoding, opcode 0000).

Reset
REQ-031 rst SHALL force state IDLE, pointer 0, byte index 0, instruction 0, instr_valid 0, ld_ready 0, load_busy 0, load_done 0, load_count 0.
REQ-032 rst SHALL NOT clear memory contents.
REQ-033 rst during RECV or WRITE SHALL abort the load; a word not yet in WRITE is discarded, earlier words stay written.

Structure
REQ-034 Shared package prog_pkg holds the FSM state encoding, the NOP constant and the opcode field position (bits INSTR_W-1:INSTR_W-4).
REQ-035 One natural sub-module: prog_byte_packer (byte index counter plus shift assembly), instantiated once.
REQ-036 Storage SHALL be a single inferred synchronous-write, registered-read array.

Verification
REQ-037 Reset then fetch_en=1 at addr 3 -> next cycle instr_valid=1, instruction=16'h0000.
REQ-038 Load stream 12,02,22,40 with ld_last on 40 -> mem[0]=16'h1202, mem[1]=16'h2240, load_count=2, one load_done pulse; fetch addr 1 returns 16'h2240.
REQ-039 Load of 33 bytes with ld_last never asserted -> 16 words written, load_count=16, ld_ready low after the 32nd byte, 33rd byte not accepted.
REQ-040 Three bytes AB,CD,EF with ld_last on EF -> mem[0]=16'hABCD, mem[1]=16'hEF00, load_count=2.
REQ-041 fetch_en and load_start in the same cycle -> instr_valid=0 next cycle, load_busy=1; fetches during load give instr_valid=0.
REQ-042 rst asserted after the 3rd byte of a load -> load_busy=0, load_count=0, mem[0] holds the first word, mem[1] unchanged.

Source files
------------

// File: rtl/prog_pkg.sv
// prog_pkg: shared FSM encoding, NOP constant and opcode field position
// for the program memory block and its byte packer.
package prog_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_FINISH} state_t;
    localparam logic [3:0] NOP_OPCODE = 4'h0;
    localparam int OPC_W = 4;
    // Opcode occupies bits instr_w-1 : instr_w-OPC_W.
    function automatic int opc_lsb(input int instr_w);
        return instr_w - OPC_W;
    endfunction
endpackage

// File: rtl/prog_byte_packer.sv
// prog_byte_packer: assembles a stream of bytes MS-byte first into one word;
// the first byte of a word clears the rest so a short word is zero-filled.
module prog_byte_packer #(
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_push,
    input  logic [7:0]         i_data,
    output logic [INSTR_W-1:0] o_word,
    output logic               o_full
);
    localparam int NB = INSTR_W / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    logic [IW-1:0]      r_idx;
    logic [INSTR_W-1:0] r_word;
    logic [INSTR_W-1:0] w_put;

    assign w_put  = INSTR_W'(i_data) << ((NB - 1 - int'(r_idx)) * 8);
    assign o_full = r_idx == IW'(NB - 1);
    assign o_word = r_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_word <= '0;
        end else begin
            if (i_clr)
                r_idx <= '0;
            else if (i_push)
                r_idx <= r_idx + 1'b1;
            if (i_push)
                r_word <= ((r_idx == '0) ? '0 : r_word) | w_put;
        end
    end
endmodule

// File: rtl/prog_mem.sv
// prog_mem: instruction memory with a 1-cycle registered fetch port and a
// byte-stream loader that rewrites words from address 0.
module prog_mem
    import prog_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    input  logic               load_start,
    input  logic               ld_valid,
    input  logic [7:0]         ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               load_busy,
    output logic               load_done,
    output logic [ADDR_W:0]    load_count
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [INSTR_W-1:0] NOP = {NOP_OPCODE, {(INSTR_W - OPC_W){1'b0}}};

    state_t             r_state, w_next;
    logic [ADDR_W-1:0]  r_ptr;
    logic [ADDR_W:0]    r_count;
    logic               r_last;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;
    logic [INSTR_W-1:0] r_mem [DEPTH] = '{default: NOP};
    logic [INSTR_W-1:0] w_word;
    logic               w_full;
    logic               w_start;
    logic               w_push;
    logic               w_write;
    logic               w_fetch;
    logic               w_ptr_end;

    assign w_start   = (r_state == S_IDLE) && load_start;
    assign w_push    = (r_state == S_RECV) && ld_valid;
    assign w_write   = r_state == S_WRITE;
    assign w_fetch   = (r_state == S_IDLE) && fetch_en && !load_start;
    assign w_ptr_end = r_ptr == ADDR_W'(DEPTH - 1);

    assign ld_ready    = r_state == S_RECV;
    assign load_busy   = r_state != S_IDLE;
    assign load_done   = r_state == S_FINISH;
    assign load_count  = r_count;
    assign instruction = r_instr;
    assign instr_valid = r_valid;

    prog_byte_packer #(.INSTR_W(INSTR_W)) u_packer (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_start || w_write),
        .i_push (w_push),
        .i_data (ld_data),
        .o_word (w_word),
        .o_full (w_full)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = load_start ? S_RECV : S_IDLE;
            S_RECV:   w_next = (w_push && (w_full || ld_last)) ? S_WRITE : S_RECV;
            S_WRITE:  w_next = (r_last || w_ptr_end) ? S_FINISH : S_RECV;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_count <= '0;
            r_last  <= 1'b0;
            r_instr <= NOP;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= w_fetch;
            if (w_fetch)
                r_instr <= r_mem[fetch_addr];
            if (w_push)
                r_last <= ld_last;
            if (w_start) begin
                r_ptr   <= '0;
                r_count <= '0;
            end else if (w_write) begin
                r_ptr   <= w_ptr_end ? r_ptr : r_ptr + 1'b1;
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Storage is deliberately outside the reset domain so rst keeps its contents.
    always_ff @(posedge clk) begin
        if (w_write)
            r_mem[r_ptr] <= w_word;
    end
endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: randomized and directed checks of prog_mem against a
// word-level memory model built from the byte stream each load offers.
module tb_prog_mem;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic [3:0]  fetch_addr = '0;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        load_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        load_busy;
    logic        load_done;
    logic [4:0]  load_count;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [15:0] mem_m [DEPTH];
    logic [7:0]  bytes [64];

    prog_mem #(.ADDR_W(ADDR_W), .INSTR_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .load_start  (load_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .load_count  (load_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (load_done === 1'b1)
            done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fetch_exp(input logic [3:0] a, input logic [15:0] exp);
        fetch_en   = 1'b1;
        fetch_addr = a;
        tick();
        fetch_en = 1'b0;
        chk("fetch_valid", instr_valid, 1);
        chk($sformatf("fetch_word[%0d]", a), instruction, exp);
    endtask

    task automatic fetch_all();
        for (int a = 0; a < DEPTH; a++)
            fetch_exp(4'(a), mem_m[a]);
    endtask

    // Offer one byte (after a random idle gap) and wait for it to be taken.
    task automatic send_byte(input logic [7:0] d, input logic last, input bit fchk);
        while ($urandom_range(0, 3) == 0) begin
            ld_valid = 1'b0;
            tick();
        end
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        for (int t = 0; t < 10 && !ld_ready; t++)
            tick();
        chk("ld_ready", ld_ready, 1);
        tick();
        if (fchk)
            chk("fetch_during_load", instr_valid, 0);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic do_load(input int n, input bit use_last, input bit with_fetch);
        int lim, words, d0;
        lim = use_last ? n : ((n < 2 * DEPTH) ? n : 2 * DEPTH);
        d0  = done_cnt;
        load_start = 1'b1;
        fetch_en   = with_fetch;
        tick();
        load_start = 1'b0;
        chk("busy_after_start", load_busy, 1);
        if (with_fetch)
            chk("start_drops_fetch", instr_valid, 0);
        for (int i = 0; i < lim; i++)
            send_byte(bytes[i], use_last && (i == n - 1), with_fetch);
        fetch_en = 1'b0;
        if (lim < n) begin
            ld_valid = 1'b1;
            ld_data  = bytes[lim];
            for (int k = 0; k < 4; k++) begin
                chk("extra_byte_not_ready", ld_ready, 0);
                tick();
            end
            ld_valid = 1'b0;
        end
        for (int t = 0; t < 10 && load_busy; t++)
            tick();
        chk("busy_after_load", load_busy, 0);
        words = (lim + 1) / 2;
        for (int w = 0; w < words; w++)
            mem_m[w] = {bytes[2 * w], (2 * w + 1 < lim) ? bytes[2 * w + 1] : 8'h00};
        chk("load_count", load_count, words);
        chk("load_done_pulses", done_cnt - d0, 1);
    endtask

    initial begin
        int n;
        bit last;
        for (int a = 0; a < DEPTH; a++)
            mem_m[a] = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_instruction", instruction, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_load_busy", load_busy, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_load_count", load_count, 0);

        fetch_exp(4'd3, 16'h0000);
        tick();
        chk("idle_no_fetch_valid", instr_valid, 0);
        fetch_all();

        bytes[0] = 8'h12; bytes[1] = 8'h02; bytes[2] = 8'h22; bytes[3] = 8'h40;
        do_load(4, 1, 0);
        fetch_exp(4'd0, 16'h1202);
        fetch_exp(4'd1, 16'h2240);
        chk("load4_count", load_count, 2);

        bytes[0] = 8'hAB; bytes[1] = 8'hCD; bytes[2] = 8'hEF;
        do_load(3, 1, 0);
        fetch_exp(4'd0, 16'hABCD);
        fetch_exp(4'd1, 16'hEF00);

        for (int i = 0; i < 33; i++)
            bytes[i] = 8'($urandom);
        do_load(33, 0, 0);
        chk("full_load_count", load_count, 16);
        fetch_all();

        bytes[0] = 8'h5A; bytes[1] = 8'hA5;
        do_load(2, 1, 1);
        fetch_all();

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h22, 1'b0, 0);
        send_byte(8'h33, 1'b0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_m[0] = 16'h1122;
        chk("abort_busy", load_busy, 0);
        chk("abort_count", load_count, 0);
        chk("abort_valid", instr_valid, 0);
        fetch_all();

        for (int r = 0; r < 8; r++) begin
            last = $urandom_range(0, 3) != 0;
            n = last ? $urandom_range(1, 32) : $urandom_range(32, 36);
            for (int i = 0; i < n; i++)
                bytes[i] = 8'($urandom);
            do_load(n, last, r[0]);
            fetch_all();
        end

        rst = 1'b1;
        tick();
        rst = 1'b0;
        fetch_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
